// File: rtl/jk_pattern_driver.sv
// Plays a WIDTH-bit pattern LSB-first as J/K excitation for an external JK flip-flop
// and checks the fed-back q against the intended sequence.
module jk_pattern_driver #(
  parameter int WIDTH      = 8,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_pattern,
  output logic                       j,
  output logic                       k,
  input  logic                       q_fb,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] err_cnt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] pat;
  logic [IW-1:0]  idx;
  logic           model_q;
  logic [1:0]     exp_bit;
  logic [1:0]     exp_vld;
  logic           flush_cnt;
  logic           accept;
  logic           last_bit;
  logic           cur_bit;
  logic           done_nxt;
  logic [1:0]     jk_nxt;

  // Excitation that moves q to b; don't-care terms resolve to 0.
  function automatic logic [1:0] excite(input logic q, input logic b);
    if (q == b)      return 2'b00;
    else if (USE_TOGGLE) return 2'b11;
    else if (b)      return 2'b10;
    else             return 2'b01;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && (state == IDLE);
  assign cur_bit  = pat[idx];
  assign last_bit = (idx == IW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    jk_nxt    = 2'b00;
    case (state)
      IDLE:  if (accept) state_nxt = RUN;
      RUN: begin
        jk_nxt = excite(model_q, cur_bit);
        if (last_bit) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Two-stage expected pipe lines each driven bit up with the q_fb it produces.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j         <= 1'b0;
      k         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      pat       <= '0;
      idx       <= '0;
      model_q   <= 1'b0;
      exp_bit   <= 2'b00;
      exp_vld   <= 2'b00;
      flush_cnt <= 1'b0;
    end else begin
      j       <= jk_nxt[1];
      k       <= jk_nxt[0];
      done    <= done_nxt;
      exp_bit <= {exp_bit[0], cur_bit};
      exp_vld <= {exp_vld[0], 1'b0};
      if (exp_vld[1] && (exp_bit[1] != q_fb)) begin
        err <= 1'b1;
        if (err_cnt != CW'(WIDTH)) err_cnt <= err_cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          model_q   <= q_fb;
          flush_cnt <= 1'b0;
          if (accept) begin
            pat     <= in_pattern;
            idx     <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
            exp_vld <= 2'b00;
          end
        end
        RUN: begin
          model_q <= cur_bit;
          exp_vld <= {exp_vld[0], 1'b1};
          if (!last_bit) idx <= idx + IW'(1);
        end
        FLUSH: flush_cnt <= ~flush_cnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Drives two pattern drivers (set/reset and toggle variants) into behavioural JK flip-flops
// and scoreboards the excitation, resulting q, and error reporting.
module tb_jk_pattern_driver;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_pattern;
  logic         in_ready0, j0, k0, busy0, done0, err0, q_fb0;
  logic         in_ready1, j1, k1, busy1, done1, err1, q_fb1;
  logic [3:0]   err_cnt0, err_cnt1;
  logic         ffq0, ffq1;
  logic         ff_preset, fb_zero, fb_inv;
  int           total;
  int           bad;

  typedef struct packed {
    logic [1:0] jk0;
    logic [1:0] jk1;
  } jk_exp_t;

  jk_exp_t sbJk[$];
  logic    sbQ[$];

  jk_pattern_driver #(.WIDTH(W), .USE_TOGGLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_pattern(in_pattern), .j(j0), .k(k0), .q_fb(q_fb0),
    .busy(busy0), .done(done0), .err(err0), .err_cnt(err_cnt0)
  );

  jk_pattern_driver #(.WIDTH(W), .USE_TOGGLE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pattern(in_pattern), .j(j1), .k(k1), .q_fb(q_fb1),
    .busy(busy1), .done(done1), .err(err1), .err_cnt(err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External JK flip-flops sharing clk/rst, with a bench-side preset for the IDLE tracking case.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ffq0 <= 1'b0;
      ffq1 <= 1'b0;
    end else if (ff_preset) begin
      ffq0 <= 1'b1;
      ffq1 <= 1'b1;
    end else begin
      case ({j0, k0})
        2'b01:   ffq0 <= 1'b0;
        2'b10:   ffq0 <= 1'b1;
        2'b11:   ffq0 <= ~ffq0;
        default: ffq0 <= ffq0;
      endcase
      case ({j1, k1})
        2'b01:   ffq1 <= 1'b0;
        2'b10:   ffq1 <= 1'b1;
        2'b11:   ffq1 <= ~ffq1;
        default: ffq1 <= ffq1;
      endcase
    end
  end

  assign q_fb0 = fb_inv ? ~ffq0 : (fb_zero ? 1'b0 : ffq0);
  assign q_fb1 = fb_inv ? ~ffq1 : (fb_zero ? 1'b0 : ffq1);

  function automatic logic [1:0] exc(input logic q, input logic b, input bit tog);
    if (q == b) return 2'b00;
    if (tog)    return 2'b11;
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 clean, 1 q_fb forced low while bit 4 is on the feedback, 2 q_fb inverted during the run.
  task automatic applyStimulus(input logic [7:0] pat, input logic q0, input int mode,
                               input bit chain, input logic [7:0] nextPat,
                               input logic expErr, input logic [3:0] expCnt);
    logic    qm;
    logic    qe;
    jk_exp_t e;
    qm         = q0;
    in_valid   = 1'b1;
    in_pattern = pat;
    for (int i = 0; i < W; i++) begin
      sbJk.push_back('{jk0: exc(qm, pat[i], 1'b0), jk1: exc(qm, pat[i], 1'b1)});
      sbQ.push_back(pat[i]);
      qm = pat[i];
    end
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (chain) in_pattern = nextPat;
        else       in_valid   = 1'b0;
        if (mode == 2) fb_inv = 1'b1;
        checkOutput("accept.busy0", busy0, 1);
        checkOutput("accept.busy1", busy1, 1);
        checkOutput("accept.ready0", in_ready0, 0);
        checkOutput("accept.done0", done0, 0);
        checkOutput("accept.err0", err0, 0);
        checkOutput("accept.err1", err1, 0);
        checkOutput("accept.cnt0", err_cnt0, 0);
      end
      if (mode == 1) fb_zero = (n == 7);
      if (n >= 2 && n <= 9) begin
        e = sbJk.pop_front();
        checkOutput($sformatf("jk0.bit%0d", n - 2), {j0, k0}, e.jk0);
        checkOutput($sformatf("jk1.bit%0d", n - 2), {j1, k1}, e.jk1);
      end
      if (n >= 3 && n <= 10) begin
        qe = sbQ.pop_front();
        checkOutput($sformatf("ffq0.bit%0d", n - 3), ffq0, qe);
        checkOutput($sformatf("ffq1.bit%0d", n - 3), ffq1, qe);
      end
      if (n == 10) begin
        checkOutput("flush.done0", done0, 0);
        checkOutput("flush.ready0", in_ready0, 0);
      end
      if (n == 11) begin
        checkOutput("end.done0", done0, 1);
        checkOutput("end.done1", done1, 1);
        checkOutput("end.ready0", in_ready0, 1);
        checkOutput("end.ready1", in_ready1, 1);
        checkOutput("end.busy0", busy0, 0);
        checkOutput("end.jk0", {j0, k0}, 2'b00);
        checkOutput("end.err0", err0, expErr);
        checkOutput("end.err1", err1, expErr);
        checkOutput("end.cnt0", err_cnt0, expCnt);
        checkOutput("end.cnt1", err_cnt1, expCnt);
        fb_inv = 1'b0;
      end
    end
  endtask

  initial begin
    logic seenDone;
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_pattern = '0;
    ff_preset  = 1'b0;
    fb_zero    = 1'b0;
    fb_inv     = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst.ready0", in_ready0, 1);
    checkOutput("rst.ready1", in_ready1, 1);
    checkOutput("rst.jk0", {j0, k0}, 2'b00);
    checkOutput("rst.jk1", {j1, k1}, 2'b00);
    checkOutput("rst.busy0", busy0, 0);
    checkOutput("rst.done0", done0, 0);
    checkOutput("rst.err0", err0, 0);
    checkOutput("rst.cnt0", err_cnt0, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] clean run 8'b1011_0010");
    applyStimulus(8'hB2, 1'b0, 0, 1'b0, 8'h00, 1'b0, 4'd0);

    $display("[TB] single disturbed feedback cycle");
    applyStimulus(8'hB2, 1'b1, 1, 1'b0, 8'h00, 1'b1, 4'd1);

    applyStimulus(8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0, 4'd0);

    $display("[TB] preset in IDLE, then back-to-back FF/00 with in_valid held");
    ff_preset = 1'b1;
    @(negedge clk);
    ff_preset = 1'b0;
    @(negedge clk);
    checkOutput("idle.track.err0", err0, 0);
    checkOutput("idle.track.busy0", busy0, 0);
    applyStimulus(8'hFF, 1'b1, 0, 1'b1, 8'h00, 1'b0, 4'd0);
    applyStimulus(8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b0, 4'd0);

    $display("[TB] reset during RUN bit 3");
    in_valid   = 1'b1;
    in_pattern = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    fb_inv   = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abort.pre.busy0", busy0, 1);
    checkOutput("abort.pre.jk0", {j0, k0}, 2'b10);
    checkOutput("abort.pre.jk1", {j1, k1}, 2'b11);
    checkOutput("abort.pre.cnt0", err_cnt0, 2);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort.jk0", {j0, k0}, 2'b00);
    checkOutput("abort.jk1", {j1, k1}, 2'b00);
    checkOutput("abort.busy0", busy0, 0);
    checkOutput("abort.ready0", in_ready0, 1);
    checkOutput("abort.cnt0", err_cnt0, 0);
    checkOutput("abort.err1", err1, 0);
    @(negedge clk);
    rst    = 1'b1;
    fb_inv = 1'b0;
    seenDone = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      seenDone = seenDone | done0 | done1;
    end
    checkOutput("abort.noDone", seenDone, 0);
    applyStimulus(8'hB2, 1'b0, 0, 1'b0, 8'h00, 1'b0, 4'd0);

    $display("[TB] inverted feedback saturation");
    applyStimulus(8'hAA, 1'b1, 2, 1'b0, 8'h00, 1'b1, 4'd8);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
